// File: rtl/dm_pkg.sv
// Shared constants, trace-entry layout and the lane-merge helper for the
// data-memory responder.
package dm_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int LANES  = WORD_W / 8;

    localparam logic [LANES-1:0] BYTEEN_W  = 4'b1111;
    localparam logic [LANES-1:0] BYTEEN_H0 = 4'b0011;
    localparam logic [LANES-1:0] BYTEEN_H1 = 4'b1100;
    localparam logic [LANES-1:0] BYTEEN_B0 = 4'b0001;
    localparam logic [LANES-1:0] BYTEEN_B1 = 4'b0010;
    localparam logic [LANES-1:0] BYTEEN_B2 = 4'b0100;
    localparam logic [LANES-1:0] BYTEEN_B3 = 4'b1000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

    // Replace each enabled byte lane of old_word with the matching lane of wdata.
    function automatic logic [WORD_W-1:0] merge_lanes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] wdata,
        input logic [LANES-1:0]  byteen
    );
        logic [WORD_W-1:0] word;
        word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (byteen[i]) word[8*i +: 8] = wdata[8*i +: 8];
        end
        return word;
    endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// Store-trace FIFO: drops pushes when full (sticky overflow), valid/ready pop,
// head forced to zero while empty.
module trace_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   ready,
    output logic                   valid,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = (count != '0);
    assign pop     = valid && ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop);
    assign head    = valid ? store[rd_ptr] : '0;

    // NOTE: entry storage has no reset; the head is gated by valid, so stale
    // contents are never observable and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_data;
    end

    // NOTE: every state register uses non-blocking assignment so all flops
    // sample pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push_ok) count <= count - CNT_W'(1);
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word reads, byte-enabled synchronous
// writes, and a trace of every committed store.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    output logic                         trc_valid,
    input  logic                         trc_ready,
    output logic [31:0]                  trc_pc,
    output logic [31:0]                  trc_addr,
    output logic [31:0]                  trc_data,
    output logic [$clog2(TRACE_DEPTH):0] trc_count,
    output logic                         trc_overflow
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  index;
    logic              in_range;
    logic              write_en;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged;
    trace_entry_t      push_entry;
    trace_entry_t      head_entry;

    assign index    = m_data_addr[IDX_W+1:2];
    // Anything at or above 4*DEPTH has a nonzero bit above the index field.
    assign in_range = (m_data_addr[ADDR_W-1:IDX_W+2] == '0);
    assign write_en = (m_data_byteen != '0) && in_range;
    assign old_word = mem[index];
    assign merged   = merge_lanes(old_word, m_data_wdata, m_data_byteen);

    // NOTE: all outputs of a combinational block get a default first so no
    // path can leave a value held, which would infer a latch.
    always_comb begin
        m_data_rdata = '0;
        if (!reset && in_range) m_data_rdata = old_word;
    end

    // The memory must read as zero right after reset, so every word is
    // cleared asynchronously; the write in the reset cycle is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (write_en) begin
            mem[index] <= merged;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = m_inst_addr;
        push_entry.addr = m_data_addr & ~32'h3;
        push_entry.data = merged;
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (write_en),
        .push_data (push_entry),
        .ready     (trc_ready),
        .valid     (trc_valid),
        .head      (head_entry),
        .count     (trc_count),
        .overflow  (trc_overflow)
    );

    assign trc_pc   = head_entry.pc;
    assign trc_addr = head_entry.addr;
    assign trc_data = head_entry.data;

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder: the memory-side end of the CPU's `m_data_*` bus. It serves same-cycle word reads and byte-enabled synchronous writes, and logs every committed store into a small trace FIFO. The FIFO is drained by a valid/ready consumer, which is the bench's store checker. It sits beside the pipelined CPU core, opposite its M-stage data interface.

## Interface
Parameters:
- `DEPTH`, 4096: memory size in 32-bit words; power of two.
- `TRACE_DEPTH`, 4: trace FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `m_data_addr` in 32: byte address from the CPU M stage.
- `m_data_wdata` in 32: lane-aligned store data.
- `m_data_byteen` in 4: byte write enables; bit i enables byte lane i (bits 8i+7:8i).
- `m_inst_addr` in 32: PC of the M-stage instruction, captured into the trace.
- `m_data_rdata` out 32: word read data.
- `trc_valid` out 1: trace head entry valid.
- `trc_ready` in 1: consumer accepts the head entry.
- `trc_pc` out 32: PC of the store.
- `trc_addr` out 32: word-aligned store address (bits 1:0 = 0).
- `trc_data` out 32: full word after the merge.
- `trc_count` out log2(TRACE_DEPTH)+1: FIFO occupancy.
- `trc_overflow` out 1: sticky; set when a trace entry was dropped.

## Operation
- Word index = `m_data_addr[log2(DEPTH)+1:2]`. The low two address bits are ignored for addressing.
- In range ⇔ `m_data_addr < 4*DEPTH`.
- Read:
  - `m_data_rdata` is combinational, `mem[index]` when in range, else 0.
  - No read strobe; it is always driven.
  - The CPU does byte/half extraction; this block always returns the full word.
- Write (store):
  - Occurs when `m_data_byteen != 0` and the address is in range.
  - At the rising edge, each enabled lane i is replaced by `m_data_wdata[8i+7:8i]`; other lanes are kept.
  - `merged` = old word with the enabled lanes replaced.
  - If out of range: the write is dropped, and there is no trace push.
- Trace push: on every committed write, enqueue {`m_inst_addr`, `{m_data_addr[31:2],2'b00}`, merged}.
- Trace pop: when `trc_valid && trc_ready` at the edge.
- Empty FIFO: `trc_valid` = 0 and `trc_pc`/`trc_addr`/`trc_data` = 0.
- Full FIFO, push with no pop: the entry is dropped, and `trc_overflow` is set until reset.
- Full FIFO, push together with pop: both happen, and the count stays at TRACE_DEPTH. Not an overflow.
- Empty FIFO, push together with `trc_ready`=1: no pop, because `trc_valid` was 0. The count becomes 1.
- Pointers are log2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH. Count arithmetic: +1 on push only, −1 on pop only, unchanged on both.
- Reset, asynchronous and taking effect mid-cycle as well:
  - All memory words become 0.
  - FIFO pointers and count become 0.
  - `trc_overflow` = 0, `trc_valid` = 0, and all `trc_*` data outputs = 0.
  - `m_data_rdata` = 0 while reset is asserted.
  - A write in flight in the reset cycle is lost.

## Timing
- Read latency is 0 cycles.
- A write committed at edge N is visible on `m_data_rdata` after edge N. A read in the same cycle as the write returns the old word.
- A trace entry pushed at edge N gives `trc_valid`=1 from after edge N; the minimum latency is 1 cycle.
- Sustained throughput is one store per cycle with `trc_ready` held at 1, with no overflow at any depth.
- `trc_*` outputs must stay stable while `trc_valid && !trc_ready`.

## Structure
- Package `dm_pkg`:
  - `BYTEEN_W`/`BYTEEN_H0`/`BYTEEN_H1`/`BYTEEN_B0..B3` constants (4'b1111, 4'b0011, 4'b1100, 4'b0001…4'b1000).
  - Word/address width constants.
  - Packed trace-entry typedef {pc, addr, data}, 96 bits.
- Sub-module `trace_fifo`: parameterized by width and depth, with push/full-drop/overflow and valid/ready pop. It is instantiated once.
- The memory array and the byte merge live in `dm_responder`.

## Test plan
- Reset, then read 0x0000_0010 → `m_data_rdata`=0, `trc_valid`=0, `trc_count`=0.
- sw at PC 0x3000: addr 0x10, wdata 0x1234_5678, byteen 1111. Then read 0x12 → rdata 0x1234_5678. Trace holds {0x3000, 0x10, 0x1234_5678}.
- sh over that word: byteen 1100, wdata 0xABCD_0000, addr 0x12. Then sb: byteen 0010, wdata 0x0000_EE00, addr 0x11.
  - Final word = 0xABCD_EE78.
  - The trace data of the two entries is 0xABCD_5678 then 0xABCD_EE78.
- `trc_ready`=0, then six stores → `trc_count`=4 and `trc_overflow`=1.
  - Draining yields exactly the first four entries, in order.
  - Check a push and pop in the same cycle while full keeps `trc_count`=4 with no extra overflow.
- Store to addr 0x0000_4000 (= 4*DEPTH) → no write and no trace push; a read of that address returns 0.
- Assert `reset` mid-cycle with 2 entries queued and a store pending:
  - All outputs clear immediately.
  - After release, a read of 0x10 returns 0.
